// File: rtl/spatz_id_scoreboard.sv
// Instruction-ID scoreboard: allocates IDs to issued vector instructions,
// tracks their destination registers for RAW/WAW stalls and retires IDs from several channels.
module spatz_id_scoreboard #(
  parameter int unsigned NrIds   = 16,
  parameter int unsigned NrVRegs = 32,
  parameter int unsigned NrRsp   = 3,
  localparam int unsigned IdW    = $clog2(NrIds),
  localparam int unsigned RegW   = $clog2(NrVRegs),
  localparam int unsigned CntW   = $clog2(NrIds + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   issue_valid_i,
  output logic                   issue_ready_o,
  input  logic [RegW-1:0]        issue_vs1_i,
  input  logic [RegW-1:0]        issue_vs2_i,
  input  logic [RegW-1:0]        issue_vd_i,
  input  logic                   issue_use_vs1_i,
  input  logic                   issue_use_vs2_i,
  input  logic                   issue_use_vd_i,
  output logic [IdW-1:0]         issue_id_o,
  input  logic [NrRsp-1:0]       rsp_valid_i,
  input  logic [NrRsp*IdW-1:0]   rsp_id_i,
  output logic [CntW-1:0]        inflight_cnt_o,
  output logic                   busy_o,
  output logic [NrVRegs-1:0]     vreg_busy_o,
  output logic                   err_o
);

  logic [NrIds-1:0]    valid_q, valid_d;
  logic [RegW-1:0]     vd_q [NrIds];
  logic [NrIds-1:0]    wvd_q;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                err_q, err_d;

  logic [NrIds-1:0]    retire_mask;
  logic [CntW-1:0]     retired_cnt;
  logic                rsp_err;
  logic [IdW-1:0]      free_id;
  logic                any_free;
  logic                hazard;
  logic                issue_fire;

  // Busy vregs come from registered state only, so a release is visible one cycle later.
  always_comb begin
    vreg_busy_o = '0;
    for (int i = 0; i < NrIds; i++) begin
      for (int r = 0; r < NrVRegs; r++) begin
        if (valid_q[i] && wvd_q[i] && (vd_q[i] == RegW'(r))) vreg_busy_o[r] = 1'b1;
      end
    end
  end

  always_comb begin
    free_id  = '0;
    any_free = 1'b0;
    for (int i = 0; i < NrIds; i++) begin
      if (!valid_q[i] && !any_free) begin
        free_id  = IdW'(i);
        any_free = 1'b1;
      end
    end
  end

  assign hazard = (issue_use_vs1_i && vreg_busy_o[issue_vs1_i]) ||
                  (issue_use_vs2_i && vreg_busy_o[issue_vs2_i]) ||
                  (issue_use_vd_i  && vreg_busy_o[issue_vd_i]);

  assign issue_ready_o = any_free && !hazard;
  assign issue_id_o    = free_id;
  assign issue_fire    = issue_valid_i && issue_ready_o;

  // Retiring a free ID, or the same ID twice in one cycle, is a protocol error.
  always_comb begin
    retire_mask = '0;
    rsp_err     = 1'b0;
    for (int k = 0; k < NrRsp; k++) begin
      if (rsp_valid_i[k]) begin
        if (!valid_q[rsp_id_i[k*IdW +: IdW]] || retire_mask[rsp_id_i[k*IdW +: IdW]]) begin
          rsp_err = 1'b1;
        end else begin
          retire_mask[rsp_id_i[k*IdW +: IdW]] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    retired_cnt = '0;
    for (int i = 0; i < NrIds; i++) begin
      retired_cnt = retired_cnt + CntW'(retire_mask[i]);
    end
  end

  always_comb begin
    valid_d = valid_q & ~retire_mask;
    if (issue_fire) valid_d[free_id] = 1'b1;
    cnt_d = cnt_q + CntW'(issue_fire) - retired_cnt;
    err_d = err_q | rsp_err;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
      wvd_q   <= '0;
      vd_q    <= '{default: '0};
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (issue_fire) begin
        vd_q[free_id]  <= issue_vd_i;
        wvd_q[free_id] <= issue_use_vd_i;
      end
    end
  end

  assign inflight_cnt_o = cnt_q;
  assign busy_o         = (cnt_q != '0);
  assign err_o          = err_q;

endmodule

// File: tb/tb_spatz_id_scoreboard.sv
// Directed self-checking bench for spatz_id_scoreboard with default parameters
// (16 IDs, 32 vregs, 3 retirement channels).
module tb_spatz_id_scoreboard;

  localparam int NrIds   = 16;
  localparam int NrVRegs = 32;
  localparam int NrRsp   = 3;
  localparam int IdW     = 4;
  localparam int RegW    = 5;
  localparam int CntW    = 5;

  logic                 clk_i;
  logic                 rst_ni;
  logic                 issue_valid_i;
  logic                 issue_ready_o;
  logic [RegW-1:0]      issue_vs1_i, issue_vs2_i, issue_vd_i;
  logic                 issue_use_vs1_i, issue_use_vs2_i, issue_use_vd_i;
  logic [IdW-1:0]       issue_id_o;
  logic [NrRsp-1:0]     rsp_valid_i;
  logic [NrRsp*IdW-1:0] rsp_id_i;
  logic [CntW-1:0]      inflight_cnt_o;
  logic                 busy_o;
  logic [NrVRegs-1:0]   vreg_busy_o;
  logic                 err_o;

  int n_cmp  = 0;
  int n_fail = 0;

  spatz_id_scoreboard #(.NrIds(NrIds), .NrVRegs(NrVRegs), .NrRsp(NrRsp)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .issue_valid_i   (issue_valid_i),
    .issue_ready_o   (issue_ready_o),
    .issue_vs1_i     (issue_vs1_i),
    .issue_vs2_i     (issue_vs2_i),
    .issue_vd_i      (issue_vd_i),
    .issue_use_vs1_i (issue_use_vs1_i),
    .issue_use_vs2_i (issue_use_vs2_i),
    .issue_use_vd_i  (issue_use_vd_i),
    .issue_id_o      (issue_id_o),
    .rsp_valid_i     (rsp_valid_i),
    .rsp_id_i        (rsp_id_i),
    .inflight_cnt_o  (inflight_cnt_o),
    .busy_o          (busy_o),
    .vreg_busy_o     (vreg_busy_o),
    .err_o           (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    issue_valid_i   = 1'b0;
    issue_vs1_i     = '0;
    issue_vs2_i     = '0;
    issue_vd_i      = '0;
    issue_use_vs1_i = 1'b0;
    issue_use_vs2_i = 1'b0;
    issue_use_vd_i  = 1'b0;
    rsp_valid_i     = '0;
    rsp_id_i        = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    #1;
  endtask

  task automatic issue_one(input logic [RegW-1:0] vd, input logic use_vd);
    issue_valid_i  = 1'b1;
    issue_vd_i     = vd;
    issue_use_vd_i = use_vd;
    tick();
    idle();
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_ni        = 1'b0;
    issue_valid_i = 1'b1;
    rsp_valid_i   = 3'b101;
    tick();
    tick();
    rst_ni = 1'b1;
    idle();
    #1;
    n_cmp++; if (inflight_cnt_o !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_cnt: got %0d want 0", inflight_cnt_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", busy_o); end
    n_cmp++; if (vreg_busy_o !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_vreg_busy: got %h want 0", vreg_busy_o); end
    n_cmp++; if (issue_id_o !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_id: got %0d want 0", issue_id_o); end
    n_cmp++; if (issue_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b want 1", issue_ready_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b want 0", err_o); end
  endtask

  task automatic test_raw_stall();
    do_reset();
    issue_valid_i  = 1'b1;
    issue_vd_i     = 5'd5;
    issue_use_vd_i = 1'b1;
    #1;
    n_cmp++; if (issue_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL raw_first_ready: got %b want 1", issue_ready_o); end
    n_cmp++; if (issue_id_o !== 4'd0) begin n_fail++; $display("[TB] FAIL raw_first_id: got %0d want 0", issue_id_o); end
    tick();
    idle();
    #1;
    n_cmp++; if (vreg_busy_o !== 32'h0000_0020) begin n_fail++; $display("[TB] FAIL raw_vreg_busy: got %h want 00000020", vreg_busy_o); end
    n_cmp++; if (inflight_cnt_o !== 5'd1) begin n_fail++; $display("[TB] FAIL raw_cnt: got %0d want 1", inflight_cnt_o); end
    n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("[TB] FAIL raw_busy: got %b want 1", busy_o); end
    issue_valid_i   = 1'b1;
    issue_vs1_i     = 5'd5;
    issue_use_vs1_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (issue_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL raw_stall_c%0d: got %b want 0", c, issue_ready_o); end
      tick();
    end
    rsp_valid_i = 3'b001;
    rsp_id_i    = {4'd0, 4'd0, 4'd0};
    #1;
    n_cmp++; if (issue_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL raw_stall_retire_cycle: got %b want 0", issue_ready_o); end
    tick();
    rsp_valid_i = '0;
    #1;
    n_cmp++; if (issue_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL raw_ready_after_retire: got %b want 1", issue_ready_o); end
    n_cmp++; if (issue_id_o !== 4'd0) begin n_fail++; $display("[TB] FAIL raw_second_id: got %0d want 0", issue_id_o); end
    tick();
    idle();
    #1;
    n_cmp++; if (inflight_cnt_o !== 5'd1) begin n_fail++; $display("[TB] FAIL raw_second_cnt: got %0d want 1", inflight_cnt_o); end
    n_cmp++; if (vreg_busy_o !== 32'h0) begin n_fail++; $display("[TB] FAIL raw_second_vreg_busy: got %h want 0", vreg_busy_o); end
  endtask

  task automatic test_waw_war();
    do_reset();
    issue_one(5'd3, 1'b1);
    issue_valid_i  = 1'b1;
    issue_vd_i     = 5'd3;
    issue_use_vd_i = 1'b1;
    #1;
    n_cmp++; if (issue_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL waw_stall: got %b want 0", issue_ready_o); end
    idle();
    issue_vs2_i     = 5'd3;
    issue_use_vs2_i = 1'b1;
    #1;
    n_cmp++; if (issue_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL raw_vs2_stall: got %b want 0", issue_ready_o); end
    idle();
    issue_vs1_i = 5'd3;
    issue_vd_i  = 5'd3;
    #1;
    n_cmp++; if (issue_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL unused_operand_ready: got %b want 1", issue_ready_o); end
    idle();
    issue_valid_i   = 1'b1;
    issue_vs1_i     = 5'd4;
    issue_use_vs1_i = 1'b1;
    tick();
    idle();
    issue_vd_i     = 5'd4;
    issue_use_vd_i = 1'b1;
    #1;
    n_cmp++; if (issue_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL war_not_tracked: got %b want 1", issue_ready_o); end
    n_cmp++; if (issue_id_o !== 4'd2) begin n_fail++; $display("[TB] FAIL war_id: got %0d want 2", issue_id_o); end
    idle();
  endtask

  task automatic test_full();
    do_reset();
    issue_valid_i = 1'b1;
    for (int i = 0; i < NrIds; i++) begin
      #1;
      n_cmp++; if (issue_id_o !== 4'(i)) begin n_fail++; $display("[TB] FAIL full_id_%0d: got %0d want %0d", i, issue_id_o, i); end
      tick();
    end
    idle();
    #1;
    n_cmp++; if (inflight_cnt_o !== 5'd16) begin n_fail++; $display("[TB] FAIL full_cnt: got %0d want 16", inflight_cnt_o); end
    n_cmp++; if (issue_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL full_ready: got %b want 0", issue_ready_o); end
    rsp_valid_i = 3'b010;
    rsp_id_i    = {4'd0, 4'd7, 4'd0};
    tick();
    idle();
    #1;
    n_cmp++; if (issue_id_o !== 4'd7) begin n_fail++; $display("[TB] FAIL full_freed_id: got %0d want 7", issue_id_o); end
    n_cmp++; if (issue_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL full_freed_ready: got %b want 1", issue_ready_o); end
    n_cmp++; if (inflight_cnt_o !== 5'd15) begin n_fail++; $display("[TB] FAIL full_freed_cnt: got %0d want 15", inflight_cnt_o); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue_one(5'd0, 1'b0);
    issue_one(5'd0, 1'b0);
    issue_one(5'd0, 1'b0);
    issue_valid_i  = 1'b1;
    issue_vd_i     = 5'd10;
    issue_use_vd_i = 1'b1;
    rsp_valid_i    = 3'b111;
    rsp_id_i       = {4'd2, 4'd1, 4'd0};
    #1;
    n_cmp++; if (issue_id_o !== 4'd3) begin n_fail++; $display("[TB] FAIL b2b_id: got %0d want 3", issue_id_o); end
    tick();
    idle();
    #1;
    n_cmp++; if (inflight_cnt_o !== 5'd1) begin n_fail++; $display("[TB] FAIL b2b_cnt: got %0d want 1", inflight_cnt_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_err: got %b want 0", err_o); end
    n_cmp++; if (vreg_busy_o !== 32'h0000_0400) begin n_fail++; $display("[TB] FAIL b2b_vreg_busy: got %h want 00000400", vreg_busy_o); end
    n_cmp++; if (issue_id_o !== 4'd0) begin n_fail++; $display("[TB] FAIL b2b_next_id: got %0d want 0", issue_id_o); end
    rsp_valid_i = 3'b010;
    rsp_id_i    = {4'd0, 4'd3, 4'd0};
    tick();
    idle();
    #1;
    n_cmp++; if (inflight_cnt_o !== 5'd0) begin n_fail++; $display("[TB] FAIL b2b_retire3_cnt: got %0d want 0", inflight_cnt_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_retire3_err: got %b want 0", err_o); end
  endtask

  task automatic test_errors();
    do_reset();
    issue_one(5'd0, 1'b0);
    issue_one(5'd0, 1'b0);
    issue_one(5'd0, 1'b0);
    rsp_valid_i = 3'b010;
    rsp_id_i    = {4'd0, 4'd9, 4'd0};
    tick();
    idle();
    #1;
    n_cmp++; if (inflight_cnt_o !== 5'd3) begin n_fail++; $display("[TB] FAIL err_bogus_cnt: got %0d want 3", inflight_cnt_o); end
    n_cmp++; if (err_o !== 1'b1) begin n_fail++; $display("[TB] FAIL err_bogus_flag: got %b want 1", err_o); end
    tick();
    tick();
    n_cmp++; if (err_o !== 1'b1) begin n_fail++; $display("[TB] FAIL err_sticky: got %b want 1", err_o); end
    rsp_valid_i = 3'b101;
    rsp_id_i    = {4'd1, 4'd0, 4'd1};
    tick();
    idle();
    #1;
    n_cmp++; if (inflight_cnt_o !== 5'd2) begin n_fail++; $display("[TB] FAIL err_dup_cnt: got %0d want 2", inflight_cnt_o); end
    n_cmp++; if (err_o !== 1'b1) begin n_fail++; $display("[TB] FAIL err_dup_flag: got %b want 1", err_o); end
    n_cmp++; if (issue_id_o !== 4'd1) begin n_fail++; $display("[TB] FAIL err_dup_free_id: got %0d want 1", issue_id_o); end
  endtask

  task automatic test_reset_busy();
    do_reset();
    for (int i = 0; i < 4; i++) issue_one(5'(i + 1), 1'b1);
    rsp_valid_i = 3'b001;
    rsp_id_i    = {4'd0, 4'd0, 4'd12};
    tick();
    idle();
    #1;
    n_cmp++; if (vreg_busy_o !== 32'h0000_001E) begin n_fail++; $display("[TB] FAIL rstb_pre_vreg_busy: got %h want 0000001e", vreg_busy_o); end
    n_cmp++; if (err_o !== 1'b1) begin n_fail++; $display("[TB] FAIL rstb_pre_err: got %b want 1", err_o); end
    rst_ni         = 1'b0;
    issue_valid_i  = 1'b1;
    issue_vd_i     = 5'd9;
    issue_use_vd_i = 1'b1;
    rsp_valid_i    = 3'b001;
    rsp_id_i       = {4'd0, 4'd0, 4'd0};
    tick();
    #1;
    n_cmp++; if (inflight_cnt_o !== 5'd0) begin n_fail++; $display("[TB] FAIL rstb_cnt: got %0d want 0", inflight_cnt_o); end
    n_cmp++; if (vreg_busy_o !== 32'h0) begin n_fail++; $display("[TB] FAIL rstb_vreg_busy: got %h want 0", vreg_busy_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rstb_err: got %b want 0", err_o); end
    n_cmp++; if (issue_id_o !== 4'd0) begin n_fail++; $display("[TB] FAIL rstb_id: got %0d want 0", issue_id_o); end
    n_cmp++; if (issue_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL rstb_ready: got %b want 1", issue_ready_o); end
    rst_ni = 1'b1;
    idle();
  endtask

  initial begin
    idle();
    rst_ni = 1'b1;
    test_reset();
    test_raw_stall();
    test_waw_war();
    test_full();
    test_back_to_back();
    test_errors();
    test_reset_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spatz_id_scoreboard.md
SPATZ_ID_SCOREBOARD -- requirements
Module: spatz_id_scoreboard

Interface
REQ-001 SHALL have parameter NrIds, default 16, number of in-flight instruction IDs (power of 2, 2..64).
REQ-002 SHALL have parameter NrVRegs, default 32, number of vector registers tracked.
REQ-003 SHALL have parameter NrRsp, default 3, number of retirement channels (CON/LSU, SLD, VFU).
REQ-004 SHALL derive IdW = $clog2(NrIds), RegW = $clog2(NrVRegs), CntW = $clog2(NrIds+1).
REQ-005 SHALL have the port list below; one clock; reset synchronous, active-low.
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  synchronous active-low reset
- issue_valid_i  in  1  instruction offered for issue
- issue_ready_o  out  1  issue accepted this cycle
- issue_vs1_i / issue_vs2_i / issue_vd_i  in  RegW each  operand registers
- issue_use_vs1_i / issue_use_vs2_i / issue_use_vd_i  in  1 each  operand used
- issue_id_o  out  IdW  ID granted to the accepted instruction
- rsp_valid_i  in  NrRsp  per-channel retirement strobe
- rsp_id_i  in  NrRsp*IdW  per-channel retiring ID, channel k in bits [k*IdW +: IdW]
- inflight_cnt_o  out  CntW  number of allocated IDs
- busy_o  out  1  inflight_cnt_o != 0
- vreg_busy_o  out  NrVRegs  bit r set when an in-flight instruction writes vreg r
- err_o  out  1  sticky protocol-error flag

Function
REQ-006 SHALL hold per ID: valid bit, vd (RegW), writes_vd bit.
REQ-007 SHALL compute vreg_busy_o[r] = OR over IDs of (valid & writes_vd & vd==r), from registered state only.
REQ-008 SHALL raise issue_ready_o combinationally when a free ID exists AND no hazard: use_vs1 & vreg_busy[vs1] (RAW), use_vs2 & vreg_busy[vs2] (RAW), use_vd & vreg_busy[vd] (WAW).
REQ-009 SHALL not track WAR hazards; issue_ready_o SHALL not depend on issue_valid_i.
REQ-010 SHALL drive issue_id_o = lowest-index free ID every cycle; value undefined-but-stable when no ID free.
REQ-011 SHALL, on issue_valid_i & issue_ready_o, set valid[issue_id_o], store vd and use_vd at the next edge.
REQ-012 SHALL, for each k with rsp_valid_i[k] and valid[rsp_id_i[k]] set, clear that valid bit at the next edge.
REQ-013 SHALL evaluate allocation and hazards on pre-edge state: an ID or vreg released in cycle N is usable no earlier than cycle N+1.
REQ-014 SHALL allow up to NrRsp retirements plus one issue in one cycle; inflight_cnt_o next = cnt + issued - distinct IDs retired.
REQ-015 SHALL, on retirement of an ID whose valid bit is clear, ignore it and set err_o.
REQ-016 SHALL, when two channels retire the same valid ID in one cycle, retire it once and set err_o.
REQ-017 SHALL keep err_o set until reset.
REQ-018 SHALL never exceed NrIds in flight; issue_ready_o=0 when inflight_cnt_o==NrIds.

Reset
REQ-019 SHALL, when rst_ni=0 at a clock edge, clear all valid bits, inflight_cnt_o=0, err_o=0, regardless of concurrent issue/retire.
REQ-020 SHALL, during reset, present issue_ready_o from cleared state only after the first edge with rst_ni=0; outputs before that edge are don't-care.
REQ-021 SHALL, after reset, present busy_o=0, vreg_busy_o=0, issue_id_o=0, issue_ready_o=1.

Verification
REQ-022 Issue vd=5 use_vd=1 -> id 0 granted; next cycle vreg_busy_o[5]=1, cnt=1; second issue vs1=5 use_vs1=1 stalls until id 0 retired, accepted one cycle after retire.
REQ-023 Issue 16 instructions use_vd=0 back-to-back (NrIds=16) -> ids 0..15, cnt=16, issue_ready_o=0; retire id 7 -> next cycle issue_id_o=7, ready=1.
REQ-024 Cycle with cnt=3 (ids 0,1,2): issue plus rsp_valid=3'b111 ids 0,1,2 -> next cnt=1, new instruction holds id 3, err_o=0.
REQ-025 Retire id 9 when not allocated -> cnt unchanged, err_o=1 and stays 1; channels 0 and 2 both retire id 1 -> cnt drops by 1, err_o=1.
REQ-026 Assert rst_ni=0 with 4 IDs in flight and simultaneous issue -> after edge cnt=0, vreg_busy_o=0, err_o=0, issue_id_o=0.
